// File: rtl/game_pkg.sv
// Shared game definitions: FSM state codes, level codes, capture mask and BCD geometry.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_WON   = 3'd4
  } state_e;

  localparam logic [2:0]  LVL_IDLE     = 3'b000;
  localparam logic [2:0]  LVL_FIRST    = 3'b001;
  localparam logic [2:0]  LVL_WON      = 3'b111;
  localparam int          POINT_COUNT  = 5;
  localparam logic [POINT_COUNT-1:0] ALL_CAPTURED = 5'b11111;
  localparam int          BCD_DIGIT_W  = 4;
  localparam int          BCD_DIGITS   = 4;
  localparam logic [15:0] BCD_MAX      = 16'h9999;

endpackage

// File: rtl/bcd_add_sat.sv
// Four-digit BCD adder with decimal carry ripple; any carry out of the top digit clamps to 9999.
module bcd_add_sat
  import game_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [4:0]  dsum_s;
  logic [4:0]  dadj_s;
  logic        carry_s;
  logic [15:0] raw_s;

  // Digit-serial decimal add, then saturate on overflow
  always_comb begin
    dsum_s  = 5'd0;
    dadj_s  = 5'd0;
    carry_s = 1'b0;
    raw_s   = 16'h0000;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      dsum_s = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]} + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
             + {4'd0, carry_s};
      dadj_s = dsum_s + 5'd6;
      if (dsum_s > 5'd9) begin
        raw_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dadj_s[3:0];
        carry_s = 1'b1;
      end else begin
        raw_s[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dsum_s[3:0];
        carry_s = 1'b0;
      end
    end
    if (carry_s) begin
      sum = BCD_MAX;
    end else begin
      sum = raw_s;
    end
  end

endmodule

// File: rtl/level_scorekeeper.sv
// Level sequencer and BCD scorekeeper sitting behind the point-capture logic.
module level_scorekeeper
  import game_pkg::*;
#(
  parameter int POINT_VALUE = 1,
  parameter int LEVEL_BONUS = 5,
  parameter int DONE_TICKS  = 120,
  parameter int LAST_LEVEL  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   start,
  input  logic                   capture_point,
  input  logic [POINT_COUNT-1:0] captured,
  output logic [2:0]             lvl,
  output logic                   points_clr,
  output logic                   level_done,
  output logic                   game_won,
  output logic [15:0]            score
);

  localparam logic [3:0] PV_DIGIT    = 4'(POINT_VALUE);
  localparam logic [3:0] BONUS_DIGIT = 4'(LEVEL_BONUS);
  localparam logic [7:0] TICK_LAST   = 8'(DONE_TICKS - 1);
  localparam logic [2:0] LAST_LVL    = 3'(LAST_LEVEL);

  state_e      state_r;
  logic [7:0]  tick_cnt_r;
  logic        full_s;
  logic [15:0] addend_s;
  logic [15:0] sum_s;

  assign full_s = (captured == ALL_CAPTURED);

  // Point and bonus occupy separate BCD digits, so one adder covers both
  always_comb begin
    addend_s = 16'h0000;
    if (state_r == ST_PLAY) begin
      addend_s = {8'h00, (full_s ? BONUS_DIGIT : 4'h0), (capture_point ? PV_DIGIT : 4'h0)};
    end else begin
      addend_s = 16'h0000;
    end
  end

  bcd_add_sat u_add (
    .a   (score),
    .b   (addend_s),
    .sum (sum_s)
  );

  // Game FSM with registered level, score and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 8'd0;
      lvl        <= LVL_IDLE;
      points_clr <= 1'b0;
      level_done <= 1'b0;
      game_won   <= 1'b0;
      score      <= 16'h0000;
    end else begin
      points_clr <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_CLEAR;
            lvl        <= LVL_FIRST;
            score      <= 16'h0000;
            points_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_r <= ST_PLAY;
        end
        ST_PLAY: begin
          score <= sum_s;
          if (full_s) begin
            state_r    <= ST_DONE;
            level_done <= 1'b1;
            tick_cnt_r <= 8'd0;
          end
        end
        ST_DONE: begin
          if (tick) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r <= 8'd0;
              level_done <= 1'b0;
              if (lvl == LAST_LVL) begin
                state_r  <= ST_WON;
                lvl      <= LVL_WON;
                game_won <= 1'b1;
              end else begin
                state_r    <= ST_CLEAR;
                lvl        <= lvl + 3'd1;
                points_clr <= 1'b1;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 8'd1;
            end
          end
        end
        ST_WON: begin
          if (start) begin
            state_r    <= ST_CLEAR;
            lvl        <= LVL_FIRST;
            score      <= 16'h0000;
            game_won   <= 1'b0;
            points_clr <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tick_cnt_r <= 8'd0;
          lvl        <= LVL_IDLE;
          level_done <= 1'b0;
          game_won   <= 1'b0;
          score      <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_scorekeeper.sv
// Randomized bench: a behavioural game model queues expected outputs per clock; a monitor compares.
module tb_level_scorekeeper;

  localparam int PV   = 1;
  localparam int LB   = 5;
  localparam int DT   = 120;
  localparam int LAST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       capture_point = 1'b0;
  logic [4:0] captured = 5'b00000;
  logic [2:0] lvl;
  logic       points_clr;
  logic       level_done;
  logic       game_won;
  logic [15:0] score;

  level_scorekeeper #(
    .POINT_VALUE (PV),
    .LEVEL_BONUS (LB),
    .DONE_TICKS  (DT),
    .LAST_LEVEL  (LAST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .start         (start),
    .capture_point (capture_point),
    .captured      (captured),
    .lvl           (lvl),
    .points_clr    (points_clr),
    .level_done    (level_done),
    .game_won      (game_won),
    .score         (score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  lvl;
    logic        clr;
    logic        done;
    logic        won;
    logic [15:0] score;
  } exp_t;

  typedef enum {M_IDLE, M_CLEAR, M_PLAY, M_DONE, M_WON} mphase_e;

  exp_t    exp_q[$];
  int      tests = 0;
  int      fails = 0;
  mphase_e m_phase = M_IDLE;
  int      m_level = 0;
  int      m_score = 0;
  int      m_ticks = 0;
  bit      m_clr = 1'b0;

  function automatic void check(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Game rules applied to one clock edge, in plain integer terms
  function automatic void model_edge(bit r, bit t, bit s, bit cp, logic [4:0] cap);
    int gain;
    if (r) begin
      m_phase = M_IDLE; m_level = 0; m_score = 0; m_ticks = 0; m_clr = 1'b0;
      return;
    end
    m_clr = 1'b0;
    case (m_phase)
      M_IDLE: if (s) begin m_phase = M_CLEAR; m_level = 1; m_score = 0; m_clr = 1'b1; end
      M_CLEAR: m_phase = M_PLAY;
      M_PLAY: begin
        gain = cp ? PV : 0;
        if (cap == 5'b11111) begin gain += LB * 10; m_phase = M_DONE; m_ticks = 0; end
        m_score = (m_score + gain > 9999) ? 9999 : m_score + gain;
      end
      M_DONE: if (t) begin
        m_ticks++;
        if (m_ticks == DT) begin
          if (m_level == LAST) m_phase = M_WON;
          else begin m_level++; m_phase = M_CLEAR; m_clr = 1'b1; end
        end
      end
      M_WON: if (s) begin m_phase = M_CLEAR; m_level = 1; m_score = 0; m_clr = 1'b1; end
      default: m_phase = M_IDLE;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.lvl   = (m_phase == M_WON) ? 3'b111 : 3'(m_level);
    e.clr   = m_clr;
    e.done  = (m_phase == M_DONE);
    e.won   = (m_phase == M_WON);
    e.score = to_bcd(m_score);
    return e;
  endfunction

  task automatic step(input bit r, input bit t, input bit s, input bit cp, input logic [4:0] cap);
    @(negedge clk);
    rst = r; tick = t; start = s; capture_point = cp; captured = cap;
    model_edge(r, t, s, cp, cap);
    exp_q.push_back(model_out());
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // CLEAR cycle: bitmask already cleared, stray capture pulses must be ignored
  task automatic clear_step();
    step(1'b0, rb(), rb(), rb(), 5'b00000);
  endtask

  task automatic play_level();
    logic [4:0] mask = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, rb(), rb(), 1'b0, mask);
      mask[i] = 1'b1;
      step(1'b0, rb(), rb(), 1'b1, mask);
    end
  endtask

  task automatic run_done(input int stop_at);
    int n = 0;
    while (m_phase == M_DONE && !(stop_at > 0 && m_ticks == stop_at)) begin
      if (n >= 2000) begin
        fails++;
        $display("FAIL done_bound: still in DONE after %0d cycles, expected exit", n);
        return;
      end
      step(1'b0, rb(), rb(), rb(), 5'b11111);
      n++;
    end
  endtask

  // Monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lvl", int'(lvl), int'(e.lvl));
        check("points_clr", int'(points_clr), int'(e.clr));
        check("level_done", int'(level_done), int'(e.done));
        check("game_won", int'(game_won), int'(e.won));
        check("score", int'(score), int'(e.score));
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'b11111);
    repeat (5) step(1'b0, rb(), 1'b0, rb(), 5'($urandom_range(0, 31)));
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);

    // Game 1: three full levels through to WON, then restart
    for (int lv = 1; lv <= LAST; lv++) begin
      clear_step();
      play_level();
      run_done(0);
    end
    repeat (6) step(1'b0, rb(), 1'b0, rb(), 5'b11111);
    step(1'b0, rb(), 1'b1, rb(), 5'b11111);

    // Game 2: async reset in the middle of the DONE countdown
    clear_step();
    play_level();
    run_done(60);
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; start = 1'b0; capture_point = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, captured);
    exp_q.push_back(model_out());
    #1;
    check("rst_async_lvl", int'(lvl), 0);
    check("rst_async_score", int'(score), 0);
    check("rst_async_level_done", int'(level_done), 0);
    check("rst_async_game_won", int'(game_won), 0);
    check("rst_async_points_clr", int'(points_clr), 0);
    step(1'b1, rb(), rb(), rb(), 5'b00000);
    repeat (4) step(1'b0, rb(), 1'b0, rb(), 5'b00000);

    // Game 3: pump captures until the score saturates, then complete the level
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
    clear_step();
    repeat (10050) step(1'b0, rb(), rb(), 1'b1, 5'b00000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b11111);
    repeat (5) step(1'b0, 1'b1, rb(), rb(), 5'b11111);

    @(negedge clk);
    tick = 1'b0; start = 1'b0; capture_point = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
